path_replayer: RTL and testbench
================================

Name: path_replayer

Overview:
- Consumer end of the maze solver's move stack.
- During a solve it mirrors the solver's push/pop stream into its own LIFO store. On the solver's done it replays the surviving path in forward order, bottom of stack first, over a valid/ready stream.
- Each beat carries the move and the absolute (x,y) cell reached. The downstream display/checker sits on that stream.

Parameters:
- DEPTH, 256, maximum stored moves (power of two).
- MOVE_W, 2, direction code width.
- COORD_W, 4, coordinate width; maze is 2^COORD_W square.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse: clear store, begin collecting.
- push  in  1  solver pushes move_in.
- poping  in  1  solver pops top (backtrack).
- move_in  in  MOVE_W  direction pushed.
- done  in  1  solver finished; freeze store, begin replay.
- out_valid  out  1  replay beat valid.
- out_ready  in  1  downstream accepts beat.
- out_move  out  MOVE_W  move of current beat.
- out_x  out  COORD_W  x after applying out_move.
- out_y  out  COORD_W  y after applying out_move.
- out_last  out  1  current beat is final path move.
- replay_done  out  1  one-cycle pulse after last beat accepted, or after an empty path.
- busy  out  1  state != IDLE.
- overflow  out  1  sticky: push attempted while full.
- path_len  out  $clog2(DEPTH)+1  current stack depth.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; sp=0, rd=0, x=y=0.
  - All outputs 0.
  - Store contents don't-care.
- States:
  - IDLE: start -> COLLECT; sp=0, overflow=0, x=y=0.
  - COLLECT: per cycle, in priority order:
    - push&poping with sp>0: overwrite mem[sp-1]=move_in; sp unchanged.
    - push&poping with sp=0: treat as push.
    - push only: if sp<DEPTH, write mem[sp] and sp++; else set overflow and discard.
    - poping only: if sp>0, sp--; pop at sp=0 ignored.
    - done: same-cycle push/pop is applied first. Next state is REPLAY with rd=0 if the final sp>0; otherwise FINISH.
    - start while in COLLECT restarts: sp=0, overflow=0.
  - REPLAY:
    - out_valid=1. out_move=mem[rd] (combinational read).
    - out_x/out_y = current x,y stepped by out_move.
    - out_last=(rd==sp-1).
    - On out_valid&out_ready: x,y take the stepped values and rd++. If out_last, go to FINISH.
    - Outputs stay stable while out_ready=0.
    - push/poping/done/start ignored.
  - FINISH: replay_done=1 for one cycle -> IDLE. out_valid=0.
- Direction codes:
  - 0 = up (y-1), 1 = right (x+1), 2 = down (y+1), 3 = left (x-1).
  - Arithmetic is modulo 2^COORD_W, so 0-1 wraps to 2^COORD_W-1 with no flag.
- path_len = sp at all times.
- Latency:
  - First replay beat valid in the cycle after done is sampled.
  - Throughput is one beat per cycle with out_ready held high.
- Reset mid-replay: immediate abort to IDLE. No replay_done.

Optional Feature:
- PATH_CHECKSUM_EN: adds output checksum[7:0].
  - Cleared on start.
  - On each accepted replay beat: checksum = {checksum[6:0],checksum[7]} ^ {out_x,out_y} (zero-extended/truncated to 8 bits).
  - Valid and stable from the replay_done pulse until the next start.
- Without the macro: no checksum port and no checksum logic.

Decomposition:
- Shared package:
  - Direction codes DIR_UP/DIR_RIGHT/DIR_DOWN/DIR_LEFT.
  - State encoding IDLE/COLLECT/REPLAY/FINISH.
  - MOVE_W default.
- One natural sub-module: path_stack_mem. DEPTH x MOVE_W register array with one synchronous write port and one asynchronous read port. Address/sp logic stays in the parent.

Test Plan:
- Push 1,1,2,2 then done, out_ready=1 -> beats (1,1,0),(1,2,0),(2,2,1),(2,2,2) given as (move,x,y). out_last on 4th beat, replay_done next cycle, path_len=4.
- Push 1,2,1, pop, push 2, done -> replayed moves 1,2,2, end position (1,2). Also verify simultaneous push&poping overwrites top without changing sp.
- Push 0 then 3 from origin -> positions (0,15) then (15,15), confirming wrap-around.
- DEPTH=4: push 5 moves -> overflow=1, path_len=4, replay emits only the first 4.
- done with sp=0 -> no out_valid, replay_done pulses in the cycle after done.
- Pseudo-random out_ready during a 10-move replay -> outputs held stable while stalled, all 10 beats in order. Assert rst low mid-replay -> busy=0 and out_valid=0 immediately.

Source files
------------

// File: rtl/path_replayer_pkg.sv
// Shared types for the path replayer: direction codes, FSM states, default move width.
package path_replayer_pkg;

  localparam int unsigned MOVE_W_DEFAULT = 2;

  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirRight = 2'd1,
    DirDown  = 2'd2,
    DirLeft  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StReplay,
    StFinish
  } state_e;

endpackage

// File: rtl/path_stack_mem.sv
// Move store: DEPTH x MOVE_W register array, one synchronous write port, one async read port.
module path_stack_mem
  import path_replayer_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned MOVE_W = MOVE_W_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       wr_en_i,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr_i,
  input  logic [MOVE_W-1:0]          wr_data_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
  output logic [MOVE_W-1:0]          rd_data_o
);

  logic [MOVE_W-1:0] mem_q [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/path_replayer.sv
// Mirrors the solver's move stack, then replays it bottom-first with absolute coordinates.
// Optional PATH_CHECKSUM_EN adds an 8-bit rotate/xor checksum of the replayed positions.
module path_replayer
  import path_replayer_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned MOVE_W  = MOVE_W_DEFAULT,
  parameter int unsigned COORD_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     push,
  input  logic                     poping,
  input  logic [MOVE_W-1:0]        move_in,
  input  logic                     done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MOVE_W-1:0]        out_move,
  output logic [COORD_W-1:0]       out_x,
  output logic [COORD_W-1:0]       out_y,
  output logic                     out_last,
  output logic                     replay_done,
  output logic                     busy,
  output logic                     overflow,
`ifdef PATH_CHECKSUM_EN
  output logic [7:0]               checksum,
`endif
  output logic [$clog2(DEPTH):0]   path_len
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned SP_W = AW + 1;

  state_e             state_q, state_d;
  logic [SP_W-1:0]    sp_q, sp_d, rd_q, rd_d, sp_m1;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d, nx, ny;
  logic               ovf_q, ovf_d;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [MOVE_W-1:0]  rd_move;
  logic               in_replay, last_beat;

  path_stack_mem #(
    .DEPTH  (DEPTH),
    .MOVE_W (MOVE_W)
  ) u_mem (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (move_in),
    .rd_addr_i (rd_q[AW-1:0]),
    .rd_data_o (rd_move)
  );

  assign sp_m1     = sp_q - SP_W'(1);
  assign in_replay = (state_q == StReplay);
  assign last_beat = in_replay && (rd_q == sp_m1);

  always_comb begin
    nx = x_q;
    ny = y_q;
    unique case (dir_e'(rd_move[1:0]))
      DirUp:    ny = y_q - COORD_W'(1);
      DirRight: nx = x_q + COORD_W'(1);
      DirDown:  ny = y_q + COORD_W'(1);
      DirLeft:  nx = x_q - COORD_W'(1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    rd_d    = rd_q;
    x_d     = x_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    wr_addr = sp_q[AW-1:0];
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCollect;
          sp_d    = '0;
          ovf_d   = 1'b0;
          x_d     = '0;
          y_d     = '0;
        end
      end
      StCollect: begin
        if (push && poping && (sp_q != '0)) begin
          wr_en   = 1'b1;
          wr_addr = sp_m1[AW-1:0];
        end else if (push) begin
          if (sp_q < SP_W'(DEPTH)) begin
            wr_en = 1'b1;
            sp_d  = sp_q + SP_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else if (poping && (sp_q != '0)) begin
          sp_d = sp_m1;
        end
        // A restart wins over a same-cycle done.
        if (start) begin
          sp_d  = '0;
          ovf_d = 1'b0;
          x_d   = '0;
          y_d   = '0;
        end else if (done) begin
          rd_d    = '0;
          state_d = (sp_d != '0) ? StReplay : StFinish;
        end
      end
      StReplay: begin
        if (out_ready) begin
          x_d  = nx;
          y_d  = ny;
          rd_d = rd_q + SP_W'(1);
          if (last_beat) begin
            state_d = StFinish;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      sp_q    <= '0;
      rd_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      rd_q    <= rd_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid   = in_replay;
  assign out_move    = in_replay ? rd_move : '0;
  assign out_x       = in_replay ? nx : '0;
  assign out_y       = in_replay ? ny : '0;
  assign out_last    = last_beat;
  assign replay_done = (state_q == StFinish);
  assign busy        = (state_q != StIdle);
  assign overflow    = ovf_q;
  assign path_len    = sp_q;

`ifdef PATH_CHECKSUM_EN
  logic [7:0]             chk_q, chk_d;
  logic [2*COORD_W+7:0]   xy_ext;

  assign xy_ext = {8'd0, out_x, out_y};

  always_comb begin
    chk_d = chk_q;
    if (start && ((state_q == StIdle) || (state_q == StCollect))) begin
      chk_d = '0;
    end else if (in_replay && out_ready) begin
      chk_d = {chk_q[6:0], chk_q[7]} ^ xy_ext[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign checksum = chk_q;
`endif

endmodule

// File: tb/tb_path_replayer.sv
// Directed + randomized bench for path_replayer against a queue-based path model.
module tb_path_replayer;

  localparam int DEPTH   = 16;
  localparam int MOVE_W  = 2;
  localparam int COORD_W = 4;
  localparam int SIDE    = 1 << COORD_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, push = 1'b0, poping = 1'b0, done = 1'b0, out_ready = 1'b0;
  logic [MOVE_W-1:0]  move_in = '0;
  logic               out_valid, out_last, replay_done, busy, overflow;
  logic [MOVE_W-1:0]  out_move;
  logic [COORD_W-1:0] out_x, out_y;
  logic [$clog2(DEPTH):0] path_len;
`ifdef PATH_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int total = 0;
  int bad   = 0;
  int unsigned stk[$];
  bit ovf_m;
  int dx[4] = '{0, 1, 0, -1};
  int dy[4] = '{-1, 0, 1, 0};

  always #5 clk = ~clk;

  path_replayer #(
    .DEPTH   (DEPTH),
    .MOVE_W  (MOVE_W),
    .COORD_W (COORD_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .push        (push),
    .poping      (poping),
    .move_in     (move_in),
    .done        (done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_move    (out_move),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_last    (out_last),
    .replay_done (replay_done),
    .busy        (busy),
    .overflow    (overflow),
`ifdef PATH_CHECKSUM_EN
    .checksum    (checksum),
`endif
    .path_len    (path_len)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_collect();
    start = 1'b1;
    tick();
    start = 1'b0;
    stk.delete();
    ovf_m = 1'b0;
    chk("collect_busy", busy, 1);
    chk("collect_len", path_len, 0);
    chk("collect_ovf", overflow, 0);
  endtask

  task automatic op(input bit p, input bit q, input int unsigned m);
    push    = p;
    poping  = q;
    move_in = m[1:0];
    tick();
    push   = 1'b0;
    poping = 1'b0;
    if (p && q && stk.size() > 0) stk[stk.size()-1] = m;
    else if (p) begin
      if (stk.size() < DEPTH) stk.push_back(m);
      else ovf_m = 1'b1;
    end else if (q && stk.size() > 0) void'(stk.pop_back());
    chk("op_len", path_len, stk.size());
    chk("op_ovf", overflow, ovf_m);
  endtask

  task automatic finish_and_replay(input bit rnd);
    int n, idx, budget, x, y, nx, ny, mv;
    int unsigned csum;
    n = stk.size();
    done = 1'b1;
    tick();
    done = 1'b0;
    if (n == 0) begin
      chk("empty_rdone", replay_done, 1);
      chk("empty_valid", out_valid, 0);
      tick();
      chk("empty_rdone_clr", replay_done, 0);
      chk("empty_busy", busy, 0);
      return;
    end
    x = 0; y = 0; idx = 0; budget = 2000; csum = 0;
    while (idx < n && budget > 0) begin
      mv = int'(stk[idx]);
      nx = (x + SIDE + dx[mv]) % SIDE;
      ny = (y + SIDE + dy[mv]) % SIDE;
      chk("beat_valid", out_valid, 1);
      chk("beat_move", out_move, mv);
      chk("beat_x", out_x, nx);
      chk("beat_y", out_y, ny);
      chk("beat_last", out_last, idx == n - 1);
      chk("beat_len", path_len, n);
      chk("beat_rdone", replay_done, 0);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (out_ready) begin
        x = nx;
        y = ny;
        csum = (((csum << 1) | (csum >> 7)) & 8'hff) ^ ((nx * SIDE + ny) & 8'hff);
        idx++;
      end
      budget--;
    end
    out_ready = 1'b0;
    chk("beats_accepted", idx, n);
    chk("fin_rdone", replay_done, 1);
    chk("fin_valid", out_valid, 0);
`ifdef PATH_CHECKSUM_EN
    chk("checksum", checksum, csum);
`endif
    tick();
    chk("fin_rdone_clr", replay_done, 0);
    chk("fin_busy", busy, 0);
  endtask

  initial begin
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdone", replay_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_len", path_len, 0);
    chk("rst_move", out_move, 0);
    chk("rst_x", out_x, 0);
    chk("rst_y", out_y, 0);
    chk("rst_last", out_last, 0);
    #12 rst = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Straight path: beats (1,1,0),(1,2,0),(2,2,1),(2,2,2).
    begin_collect();
    op(1, 0, 1); op(1, 0, 1); op(1, 0, 2); op(1, 0, 2);
    finish_and_replay(0);

    // Backtrack then overwrite-in-place.
    begin_collect();
    op(1, 0, 1); op(1, 0, 2); op(1, 0, 1); op(0, 1, 0); op(1, 0, 2);
    op(1, 1, 3); op(1, 1, 2);
    finish_and_replay(0);

    // Pop on empty ignored, push&pop on empty acts as push; wrap at origin.
    begin_collect();
    op(0, 1, 0); op(1, 1, 0); op(1, 0, 3);
    finish_and_replay(0);

    // Restart while collecting.
    begin_collect();
    op(1, 0, 2); op(1, 0, 2);
    begin_collect();
    op(1, 0, 1);
    finish_and_replay(0);

    // Overflow: extra pushes are dropped, flag sticks.
    begin_collect();
    for (int i = 0; i < DEPTH + 2; i++) op(1, 0, $urandom_range(0, 3));
    op(1, 1, 0);
    finish_and_replay(0);

    // Empty path.
    begin_collect();
    finish_and_replay(0);

    // 10-move path with random backpressure.
    begin_collect();
    for (int i = 0; i < 10; i++) op(1, 0, $urandom_range(0, 3));
    finish_and_replay(1);

    // Random op mixes.
    for (int r = 0; r < 4; r++) begin
      begin_collect();
      for (int i = 0; i < 30; i++) begin
        int k;
        k = $urandom_range(0, 3);
        op(k < 2, k >= 2, $urandom_range(0, 3));
      end
      finish_and_replay(1);
    end

    // Reset in the middle of a replay aborts with no replay_done.
    begin_collect();
    for (int i = 0; i < 10; i++) op(1, 0, $urandom_range(0, 3));
    done = 1'b1;
    tick();
    done = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_rdone", replay_done, 0);
    chk("abort_len", path_len, 0);
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_abort_busy", busy, 0);
    chk("post_abort_rdone", replay_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
